// File: rtl/pipe_ctrl_regs.sv
// Control-field pipeline registers (ID/EX, EX/MEM, MEM/WB) for the 5-stage CPU,
// with stall/flush bubble insertion and saturating performance counters.
module pipe_ctrl_regs #(
    parameter int CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wpcir,
    input  logic             flush,
    input  logic             dwreg,
    input  logic             dm2reg,
    input  logic             dwmem,
    input  logic             djal,
    input  logic [3:0]       daluc,
    input  logic             daluimm,
    input  logic             dshift,
    input  logic [4:0]       drn,
    output logic             dvalid,
    output logic             evalid,
    output logic             ewreg,
    output logic             em2reg,
    output logic             ewmem,
    output logic             ejal,
    output logic             eshift,
    output logic             ealuimm,
    output logic [3:0]       ealuc,
    output logic [4:0]       ern,
    output logic             mvalid,
    output logic             mwreg,
    output logic             mm2reg,
    output logic             mwmem,
    output logic [4:0]       mrn,
    output logic             wvalid,
    output logic             wwreg,
    output logic             wm2reg,
    output logic [4:0]       wrn,
    output logic [CNT_W-1:0] retired,
    output logic [CNT_W-1:0] stalls,
    output logic [CNT_W-1:0] flushes
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic logic [CNT_W-1:0] sat_inc(
        input logic [CNT_W-1:0] v,
        input logic             en
    );
        return (en && v != CNT_MAX) ? v + CNT_ONE : v;
    endfunction

    // An ID instruction advances into EX only when it is live and not stalled
    logic advance;
    assign advance = wpcir & dvalid;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dvalid  <= 1'b0;
            evalid  <= 1'b0;
            ewreg   <= 1'b0;
            em2reg  <= 1'b0;
            ewmem   <= 1'b0;
            ejal    <= 1'b0;
            eshift  <= 1'b0;
            ealuimm <= 1'b0;
            ealuc   <= 4'd0;
            ern     <= 5'd0;
            mvalid  <= 1'b0;
            mwreg   <= 1'b0;
            mm2reg  <= 1'b0;
            mwmem   <= 1'b0;
            mrn     <= 5'd0;
            wvalid  <= 1'b0;
            wwreg   <= 1'b0;
            wm2reg  <= 1'b0;
            wrn     <= 5'd0;
            retired <= '0;
            stalls  <= '0;
            flushes <= '0;
        end else begin
            if (wpcir) begin
                dvalid <= ~flush;
            end

            evalid  <= advance;
            ewreg   <= advance & dwreg;
            em2reg  <= advance & dm2reg;
            ewmem   <= advance & dwmem;
            ejal    <= advance & djal;
            eshift  <= advance & dshift;
            ealuimm <= advance & daluimm;
            ealuc   <= advance ? daluc : 4'd0;
            ern     <= advance ? drn : 5'd0;

            mvalid  <= evalid;
            mwreg   <= ewreg;
            mm2reg  <= em2reg;
            mwmem   <= ewmem;
            mrn     <= ern;

            wvalid  <= mvalid;
            wwreg   <= mwreg;
            wm2reg  <= mm2reg;
            wrn     <= mrn;

            retired <= sat_inc(retired, mvalid);
            stalls  <= sat_inc(stalls, ~wpcir);
            flushes <= sat_inc(flushes, wpcir & flush & dvalid);
        end
    end

endmodule

// File: tb/tb_pipe_ctrl_regs.sv
// Randomized bench for pipe_ctrl_regs against an instruction-slot model,
// run on a 32-bit-counter and a 4-bit-counter instance in parallel.
module tb_pipe_ctrl_regs;

    logic clock = 1'b0;
    logic reset;
    logic wpcir, flush;
    logic dwreg, dm2reg, dwmem, djal, daluimm, dshift;
    logic [3:0] daluc;
    logic [4:0] drn;

    logic a_dvalid, a_evalid, a_ewreg, a_em2reg, a_ewmem, a_ejal, a_eshift, a_ealuimm;
    logic [3:0] a_ealuc;
    logic [4:0] a_ern, a_mrn, a_wrn;
    logic a_mvalid, a_mwreg, a_mm2reg, a_mwmem;
    logic a_wvalid, a_wwreg, a_wm2reg;
    logic [31:0] a_retired, a_stalls, a_flushes;

    logic b_dvalid, b_evalid, b_ewreg, b_em2reg, b_ewmem, b_ejal, b_eshift, b_ealuimm;
    logic [3:0] b_ealuc;
    logic [4:0] b_ern, b_mrn, b_wrn;
    logic b_mvalid, b_mwreg, b_mm2reg, b_mwmem;
    logic b_wvalid, b_wwreg, b_wm2reg;
    logic [3:0] b_retired, b_stalls, b_flushes;

    always #5 clock = ~clock;

    pipe_ctrl_regs dut (
        .clock(clock), .reset(reset), .wpcir(wpcir), .flush(flush),
        .dwreg(dwreg), .dm2reg(dm2reg), .dwmem(dwmem), .djal(djal),
        .daluc(daluc), .daluimm(daluimm), .dshift(dshift), .drn(drn),
        .dvalid(a_dvalid), .evalid(a_evalid), .ewreg(a_ewreg), .em2reg(a_em2reg),
        .ewmem(a_ewmem), .ejal(a_ejal), .eshift(a_eshift), .ealuimm(a_ealuimm),
        .ealuc(a_ealuc), .ern(a_ern), .mvalid(a_mvalid), .mwreg(a_mwreg),
        .mm2reg(a_mm2reg), .mwmem(a_mwmem), .mrn(a_mrn), .wvalid(a_wvalid),
        .wwreg(a_wwreg), .wm2reg(a_wm2reg), .wrn(a_wrn),
        .retired(a_retired), .stalls(a_stalls), .flushes(a_flushes)
    );

    pipe_ctrl_regs #(.CNT_W(4)) dut4 (
        .clock(clock), .reset(reset), .wpcir(wpcir), .flush(flush),
        .dwreg(dwreg), .dm2reg(dm2reg), .dwmem(dwmem), .djal(djal),
        .daluc(daluc), .daluimm(daluimm), .dshift(dshift), .drn(drn),
        .dvalid(b_dvalid), .evalid(b_evalid), .ewreg(b_ewreg), .em2reg(b_em2reg),
        .ewmem(b_ewmem), .ejal(b_ejal), .eshift(b_eshift), .ealuimm(b_ealuimm),
        .ealuc(b_ealuc), .ern(b_ern), .mvalid(b_mvalid), .mwreg(b_mwreg),
        .mm2reg(b_mm2reg), .mwmem(b_mwmem), .mrn(b_mrn), .wvalid(b_wvalid),
        .wwreg(b_wwreg), .wm2reg(b_wm2reg), .wrn(b_wrn),
        .retired(b_retired), .stalls(b_stalls), .flushes(b_flushes)
    );

    typedef struct packed {
        logic       v;
        logic       wreg;
        logic       m2reg;
        logic       wmem;
        logic       jal;
        logic       shift;
        logic       aluimm;
        logic [3:0] aluc;
        logic [4:0] rn;
    } slot_t;

    // Model: one ID liveness flag plus the instruction slots in EX, MEM, WB
    slot_t  pipe [3];
    logic   m_dvalid;
    longint n_ret, n_stl, n_fl;

    int checks = 0;
    int fails  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] sat(input longint c, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return 32'(c > mx ? mx : c);
    endfunction

    task automatic model_reset();
        m_dvalid = 1'b0;
        for (int i = 0; i < 3; i++) pipe[i] = '0;
        n_ret = 0;
        n_stl = 0;
        n_fl  = 0;
    endtask

    task automatic model_step();
        slot_t nid;
        if (reset) begin
            model_reset();
            return;
        end
        if (pipe[1].v) n_ret++;
        if (!wpcir) n_stl++;
        if (wpcir && flush && m_dvalid) n_fl++;
        nid = '0;
        if (wpcir && m_dvalid) begin
            nid.v      = 1'b1;
            nid.wreg   = dwreg;
            nid.m2reg  = dm2reg;
            nid.wmem   = dwmem;
            nid.jal    = djal;
            nid.shift  = dshift;
            nid.aluimm = daluimm;
            nid.aluc   = daluc;
            nid.rn     = drn;
        end
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        pipe[0] = nid;
        if (wpcir) m_dvalid = !flush;
    endtask

    task automatic check_all();
        check("dvalid",  32'(a_dvalid),  32'(m_dvalid));
        check("evalid",  32'(a_evalid),  32'(pipe[0].v));
        check("ewreg",   32'(a_ewreg),   32'(pipe[0].wreg));
        check("em2reg",  32'(a_em2reg),  32'(pipe[0].m2reg));
        check("ewmem",   32'(a_ewmem),   32'(pipe[0].wmem));
        check("ejal",    32'(a_ejal),    32'(pipe[0].jal));
        check("eshift",  32'(a_eshift),  32'(pipe[0].shift));
        check("ealuimm", 32'(a_ealuimm), 32'(pipe[0].aluimm));
        check("ealuc",   32'(a_ealuc),   32'(pipe[0].aluc));
        check("ern",     32'(a_ern),     32'(pipe[0].rn));
        check("mvalid",  32'(a_mvalid),  32'(pipe[1].v));
        check("mwreg",   32'(a_mwreg),   32'(pipe[1].wreg));
        check("mm2reg",  32'(a_mm2reg),  32'(pipe[1].m2reg));
        check("mwmem",   32'(a_mwmem),   32'(pipe[1].wmem));
        check("mrn",     32'(a_mrn),     32'(pipe[1].rn));
        check("wvalid",  32'(a_wvalid),  32'(pipe[2].v));
        check("wwreg",   32'(a_wwreg),   32'(pipe[2].wreg));
        check("wm2reg",  32'(a_wm2reg),  32'(pipe[2].m2reg));
        check("wrn",     32'(a_wrn),     32'(pipe[2].rn));
        check("retired", a_retired, sat(n_ret, 32));
        check("stalls",  a_stalls,  sat(n_stl, 32));
        check("flushes", a_flushes, sat(n_fl, 32));
        check("b_dvalid",  32'(b_dvalid),  32'(m_dvalid));
        check("b_wrn",     32'(b_wrn),     32'(pipe[2].rn));
        check("b_retired", 32'(b_retired), sat(n_ret, 4));
        check("b_stalls",  32'(b_stalls),  sat(n_stl, 4));
        check("b_flushes", 32'(b_flushes), sat(n_fl, 4));
    endtask

    // Called right after a negedge; returns right after the next negedge
    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
        check_all();
        @(negedge clock);
    endtask

    task automatic set_fields(input logic w, input logic [4:0] rn, input logic m2r);
        dwreg = w; dm2reg = m2r; dwmem = 1'b0; djal = 1'b0;
        daluc = 4'd3; daluimm = 1'b1; dshift = 1'b0; drn = rn;
    endtask

    initial begin
        reset = 1'b1;
        wpcir = 1'b1;
        flush = 1'b0;
        set_fields(1'b0, 5'd0, 1'b0);
        model_reset();
        @(negedge clock);
        tick();
        check("rst_dvalid",  32'(a_dvalid), 32'd0);
        check("rst_retired", a_retired, 32'd0);
        reset = 1'b0;

        // Straight-line flow of one instruction stream
        set_fields(1'b1, 5'd5, 1'b0);
        tick();
        check("t1_dvalid", 32'(a_dvalid), 32'd1);
        tick();
        check("t2_evalid", 32'(a_evalid), 32'd1);
        check("t2_ern",    32'(a_ern),    32'd5);
        tick();
        check("t3_mrn", 32'(a_mrn), 32'd5);
        tick();
        check("t4_wrn",     32'(a_wrn),   32'd5);
        check("t4_wwreg",   32'(a_wwreg), 32'd1);
        check("t4_retired", a_retired,    32'd1);

        // Load-use stall
        set_fields(1'b1, 5'd8, 1'b1);
        wpcir = 1'b0;
        tick();
        check("lu_ewreg",  32'(a_ewreg),  32'd0);
        check("lu_ern",    32'(a_ern),    32'd0);
        check("lu_evalid", 32'(a_evalid), 32'd0);
        check("lu_dvalid", 32'(a_dvalid), 32'd1);
        check("lu_stalls", a_stalls,      32'd1);
        wpcir = 1'b1;
        tick();
        check("lu_mrn", 32'(a_mrn), 32'd0);
        check("lu_ern8", 32'(a_ern), 32'd8);

        // Taken branch squashes the next ID slot
        flush = 1'b1;
        tick();
        check("br_dvalid",  32'(a_dvalid), 32'd0);
        check("br_flushes", a_flushes,     32'd1);
        flush = 1'b0;
        tick();
        check("br_evalid", 32'(a_evalid), 32'd0);

        // Stall beats flush
        wpcir = 1'b0;
        flush = 1'b1;
        tick();
        check("sf_dvalid",  32'(a_dvalid), 32'd1);
        check("sf_flushes", a_flushes,     32'd1);
        check("sf_stalls",  a_stalls,      32'd2);
        flush = 1'b0;

        // Saturation of the 4-bit instance
        for (int i = 0; i < 20; i++) tick();
        check("sat_stalls4",  32'(b_stalls), 32'd15);
        check("sat_stalls32", a_stalls,      32'd22);
        tick();
        check("sat_hold4", 32'(b_stalls), 32'd15);

        // Asynchronous reset with a live instruction in EX
        wpcir = 1'b1;
        tick();
        tick();
        check("ar_pre_evalid", 32'(a_evalid), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        check("ar_evalid",  32'(a_evalid), 32'd0);
        check("ar_stalls",  a_stalls,      32'd0);
        check("ar_retired", 32'(b_retired), 32'd0);
        @(negedge clock);
        tick();
        reset = 1'b0;

        // Randomized traffic with occasional mid-cycle resets
        for (int c = 0; c < 600; c++) begin
            wpcir   = ($urandom_range(0, 9) < 8);
            flush   = ($urandom_range(0, 9) < 2);
            dwreg   = 1'($urandom);
            dm2reg  = 1'($urandom);
            dwmem   = 1'($urandom);
            djal    = 1'($urandom);
            daluimm = 1'($urandom);
            dshift  = 1'($urandom);
            daluc   = 4'($urandom);
            drn     = 5'($urandom);
            if ($urandom_range(0, 99) == 0) begin
                #2;
                reset = 1'b1;
                #1;
                model_reset();
                check_all();
                @(negedge clock);
                tick();
                reset = 1'b0;
            end else begin
                tick();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
